// File: rtl/ov7670_capture_if.sv
// ov7670_capture_if: camera pixel bus in, frame-buffer write port out.
// master = capture stage (reads camera pins, drives writes); slave = the other side.
// test_pattern exists only when CAPTURE_TESTPATTERN_EN is defined.
interface ov7670_capture_if;
   logic        cam_pclk;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        capture_en;
`ifdef CAPTURE_TESTPATTERN_EN
   logic        test_pattern;
`endif
   logic [18:0] frame_addr;
   logic [3:0]  frame_pixel;
   logic        frame_we;
   logic        frame_done;
   logic        overflow;

   modport master (
      input  cam_pclk, cam_vsync, cam_href, cam_data, capture_en,
`ifdef CAPTURE_TESTPATTERN_EN
      input  test_pattern,
`endif
      output frame_addr, frame_pixel, frame_we, frame_done, overflow
   );

   modport slave (
      output cam_pclk, cam_vsync, cam_href, cam_data, capture_en,
`ifdef CAPTURE_TESTPATTERN_EN
      output test_pattern,
`endif
      input  frame_addr, frame_pixel, frame_we, frame_done, overflow
   );
endinterface

// File: rtl/ov7670_capture.sv
// ov7670_capture: samples the OV7670 RGB565 bus in clk25, converts to 4-bit gray, writes the frame buffer.
// Latency: 3 clk25 from the pin sample of a pixel's second PCLK rise to frame_we (same for frame_done).
// Backpressure: none; the buffer must take one write per 4 clk25. CAPTURE_TESTPATTERN_EN adds column bands.
module ov7670_capture #(
   parameter int H_REZ = 640,
   parameter int V_REZ = 480
) (
   input  logic             clk25,
   input  logic             rst_n,
   ov7670_capture_if.master bus
);
   localparam logic [18:0] FRAME_PIXELS = 19'(H_REZ * V_REZ);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ARM, S_CAP} state_t;
   state_t state, state_nxt;

   logic        s1_pclk, s2_pclk, prev_pclk;
   logic        s1_vsync, s2_vsync, prev_vsync;
   logic        s1_href, s2_href;
   logic [7:0]  s1_data, s2_data;

   logic        pclk_rise, vs_rise, vs_fall;
   logic        frame_start, frame_end;

   logic        phase;
   logic [7:0]  hi;
   logic [9:0]  col;
   logic [18:0] addr;

   logic [18:0] waddr;
   logic [3:0]  wpix;
   logic        we, done, ovf;

   logic [15:0] rgb;
   logic [5:0]  r6, g6, b6;
   logic [7:0]  sum;
   logic [3:0]  gray, pixel_val;
   logic        unused_sum;

   // Two-flop synchronizers on every camera pin, plus one history stage for edge detection.
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         s1_pclk <= 1'b0;  s2_pclk <= 1'b0;  prev_pclk <= 1'b0;
         s1_vsync <= 1'b0; s2_vsync <= 1'b0; prev_vsync <= 1'b0;
         s1_href <= 1'b0;  s2_href <= 1'b0;
         s1_data <= 8'd0;  s2_data <= 8'd0;
      end else begin
         s1_pclk <= bus.cam_pclk;   s2_pclk <= s1_pclk;   prev_pclk <= s2_pclk;
         s1_vsync <= bus.cam_vsync; s2_vsync <= s1_vsync; prev_vsync <= s2_vsync;
         s1_href <= bus.cam_href;   s2_href <= s1_href;
         s1_data <= bus.cam_data;   s2_data <= s1_data;
      end
   end

   assign pclk_rise = s2_pclk & ~prev_pclk;
   assign vs_rise   = s2_vsync & ~prev_vsync;
   assign vs_fall   = ~s2_vsync & prev_vsync;

   // RGB565 to gray: widen R and B to 6 bits, weight G twice, keep the top nibble.
   assign rgb        = {hi, s2_data};
   assign r6         = {rgb[15:11], rgb[15]};
   assign g6         = rgb[10:5];
   assign b6         = {rgb[4:0], rgb[4]};
   assign sum        = {2'b00, r6} + {1'b0, g6, 1'b0} + {2'b00, b6};
   assign gray       = sum[7:4];
   assign unused_sum = ^sum[3:0];

`ifdef CAPTURE_TESTPATTERN_EN
   assign pixel_val = bus.test_pattern ? col[9:6] : gray;
`else
   assign pixel_val = gray;
`endif

   // FSM state register.
   always_ff @(posedge clk25) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Frame-aligned start/stop: capture begins only on a vsync fall after an armed vsync rise.
   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state)
         S_IDLE: if (bus.capture_en) state_nxt = S_SYNC;
         S_SYNC: begin
            if (!bus.capture_en) state_nxt = S_IDLE;
            else if (vs_rise)    state_nxt = S_ARM;
         end
         S_ARM: begin
            if (vs_fall) begin
               state_nxt   = S_CAP;
               frame_start = 1'b1;
            end
         end
         S_CAP: begin
            if (vs_rise) begin
               frame_end = 1'b1;
               state_nxt = bus.capture_en ? S_ARM : S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Byte pairing, column count and buffer writes; writes past the frame size set the sticky overflow.
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         phase <= 1'b0;
         hi    <= 8'd0;
         col   <= 10'd0;
         addr  <= 19'd0;
         waddr <= 19'd0;
         wpix  <= 4'd0;
         we    <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         we   <= 1'b0;
         done <= frame_end;
         if (frame_start) begin
            addr  <= 19'd0;
            phase <= 1'b0;
            col   <= 10'd0;
            ovf   <= 1'b0;
         end else if (!s2_href) begin
            phase <= 1'b0;
            col   <= 10'd0;
         end else if (state == S_CAP && pclk_rise) begin
            if (!phase) begin
               hi    <= s2_data;
               phase <= 1'b1;
            end else begin
               phase <= 1'b0;
               col   <= col + 10'd1;
               if (addr < FRAME_PIXELS) begin
                  we    <= 1'b1;
                  waddr <= addr;
                  wpix  <= pixel_val;
                  addr  <= addr + 19'd1;
               end else begin
                  ovf <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.frame_addr  = waddr;
   assign bus.frame_pixel = wpix;
   assign bus.frame_we    = we;
   assign bus.frame_done  = done;
   assign bus.overflow    = ovf;
endmodule
